// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : digit_scan_ctrl                                                  |
// | Brief   : Multiplexed-display digit scanner driving a 2-to-4 decoder.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module digit_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    output logic       en,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ON      = 2'd1;
    localparam logic [1:0] c_ST_GAP     = 2'd2;
    localparam logic [7:0] c_DWELL_LOAD = 8'(DWELL - 1);
    localparam logic [7:0] c_GAP_LOAD   = 8'(GAP - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic [3:0] r_mask;
    logic [3:0] w_mask_nxt;
    logic       r_en;
    logic       w_en_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_frame_done;
    logic       w_frame_done_nxt;

    // First set bit strictly above cur, wrapping modulo 4; cur itself if it is the only one.
    function automatic logic [1:0] next_idx(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] idx;
        next_idx = cur;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (m[idx]) next_idx = idx;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= 8'd0;
            r_sel        <= 2'd0;
            r_mask       <= 4'd0;
            r_en         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sel        <= w_sel_nxt;
            r_mask       <= w_mask_nxt;
            r_en         <= w_en_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_mask_nxt  = r_mask;
        case (r_state)
            c_ST_ON: begin
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_sel_nxt   = 2'd0;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = c_ST_GAP;
                    w_cnt_nxt   = c_GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            c_ST_GAP: begin
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_sel_nxt   = 2'd0;
                end else if (r_cnt == 8'd0) begin
                    if (mask == 4'd0) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = 8'd0;
                        w_sel_nxt   = 2'd0;
                    end else begin
                        w_state_nxt = c_ST_ON;
                        w_cnt_nxt   = c_DWELL_LOAD;
                        w_sel_nxt   = next_idx(mask, r_sel);
                        w_mask_nxt  = mask;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 8'd0;
                w_sel_nxt   = 2'd0;
                if (start && !stop && (mask != 4'd0)) begin
                    w_state_nxt = c_ST_ON;
                    w_cnt_nxt   = c_DWELL_LOAD;
                    w_sel_nxt   = next_idx(mask, 2'd3);
                    w_mask_nxt  = mask;
                end
            end
        endcase
    end

    // Outputs are precomputed from the next state so they leave a register.
    always_comb begin
        w_en_nxt         = (w_state_nxt == c_ST_ON);
        w_busy_nxt       = (w_state_nxt != c_ST_IDLE);
        w_frame_done_nxt = (w_state_nxt == c_ST_ON) && (w_cnt_nxt == 8'd0) &&
                           (next_idx(w_mask_nxt, w_sel_nxt) <= w_sel_nxt);
    end

    assign sel        = r_sel;
    assign en         = r_en;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_digit_scan_ctrl                                               |
// | Brief   : Scoreboard bench for digit_scan_ctrl with DWELL=4, GAP=1.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_digit_scan_ctrl;

    localparam int DWELL = 4;
    localparam int GAP   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] mask = 4'd0;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry is {sel, en, busy, frame_done} expected after one clock edge.
    logic [4:0] sb[$];

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DWELL(DWELL), .GAP(GAP)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mask       (mask),
        .sel        (sel),
        .en         (en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb.push_back(5'b00_0_0_0);
    endtask

    // One digit slot: DWELL enabled cycles (frame_done on the last if wrapping) then GAP dark cycles.
    task automatic push_digit(input logic [1:0] s, input logic fd);
        for (int i = 0; i < DWELL; i++)
            sb.push_back({s, 1'b1, 1'b1, (fd && (i == DWELL - 1))});
        for (int i = 0; i < GAP; i++)
            sb.push_back({s, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic test_reset;
        logic [4:0] exp;
        int k;
        sb.delete();
        push_idle(4);
        for (int i = 0; i < 3; i++) sb.push_back({2'd0, 1'b1, 1'b1, 1'b0});
        push_idle(2);
        k = 0;
        while (sb.size() > 0) begin
            rst   = (k < 2) || (k == 7);
            start = (k < 2) || (k == 4);
            mask  = 4'b1111;
            stop  = 1'b0;
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++;
            if ({sel, en, busy, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got sel=%b en=%b busy=%b fd=%b, want sel=%b en=%b busy=%b fd=%b",
                         k, sel, en, busy, frame_done, exp[4:3], exp[2], exp[1], exp[0]);
            end
            k++;
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_full_mask;
        logic [4:0] exp;
        int k;
        sb.delete();
        for (int f = 0; f < 2; f++) begin
            push_digit(2'd0, 1'b0);
            push_digit(2'd1, 1'b0);
            push_digit(2'd2, 1'b0);
            push_digit(2'd3, 1'b1);
        end
        push_idle(1);
        k = 0;
        while (sb.size() > 0) begin
            mask  = 4'b1111;
            start = (k == 0);
            stop  = (k == 40);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++;
            if ({sel, en, busy, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL full_mask cyc %0d: got sel=%b en=%b busy=%b fd=%b, want sel=%b en=%b busy=%b fd=%b",
                         k, sel, en, busy, frame_done, exp[4:3], exp[2], exp[1], exp[0]);
            end
            k++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_sparse_mask;
        logic [4:0] exp;
        int k;
        sb.delete();
        for (int f = 0; f < 2; f++) begin
            push_digit(2'd1, 1'b0);
            push_digit(2'd3, 1'b1);
        end
        push_idle(1);
        k = 0;
        while (sb.size() > 0) begin
            mask  = 4'b1010;
            start = (k == 0);
            stop  = (k == 20);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++;
            if ({sel, en, busy, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL sparse_mask cyc %0d: got sel=%b en=%b busy=%b fd=%b, want sel=%b en=%b busy=%b fd=%b",
                         k, sel, en, busy, frame_done, exp[4:3], exp[2], exp[1], exp[0]);
            end
            k++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_single_digit;
        logic [4:0] exp;
        int k;
        sb.delete();
        for (int f = 0; f < 3; f++) push_digit(2'd2, 1'b1);
        push_idle(1);
        k = 0;
        while (sb.size() > 0) begin
            mask  = 4'b0100;
            start = (k == 0);
            stop  = (k == 15);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++;
            if ({sel, en, busy, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL single_digit cyc %0d: got sel=%b en=%b busy=%b fd=%b, want sel=%b en=%b busy=%b fd=%b",
                         k, sel, en, busy, frame_done, exp[4:3], exp[2], exp[1], exp[0]);
            end
            k++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    // Stop on the 2nd enabled cycle of sel=01, then start attempts that must be ignored.
    task automatic test_stop;
        logic [4:0] exp;
        int k;
        sb.delete();
        push_digit(2'd0, 1'b0);
        sb.push_back({2'd1, 1'b1, 1'b1, 1'b0});
        sb.push_back({2'd1, 1'b1, 1'b1, 1'b0});
        push_idle(6);
        k = 0;
        while (sb.size() > 0) begin
            mask  = (k >= 8 && k <= 10) ? 4'b0000 : 4'b0011;
            start = (k == 0) || (k == 8) || (k == 11);
            stop  = (k == 7) || (k == 11);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++;
            if ({sel, en, busy, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL stop cyc %0d: got sel=%b en=%b busy=%b fd=%b, want sel=%b en=%b busy=%b fd=%b",
                         k, sel, en, busy, frame_done, exp[4:3], exp[2], exp[1], exp[0]);
            end
            k++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_mask_drop;
        logic [4:0] exp;
        int k;
        sb.delete();
        push_digit(2'd0, 1'b0);
        push_idle(4);
        k = 0;
        while (sb.size() > 0) begin
            mask  = (k < 2) ? 4'b1111 : 4'b0000;
            start = (k == 0);
            stop  = 1'b0;
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++;
            if ({sel, en, busy, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL mask_drop cyc %0d: got sel=%b en=%b busy=%b fd=%b, want sel=%b en=%b busy=%b fd=%b",
                         k, sel, en, busy, frame_done, exp[4:3], exp[2], exp[1], exp[0]);
            end
            k++;
        end
        start = 1'b0;
    endtask

    // start held high while busy; mid-dwell mask change only takes effect at the gap exit.
    task automatic test_busy_mask_change;
        logic [4:0] exp;
        int k;
        sb.delete();
        push_digit(2'd0, 1'b0);
        push_digit(2'd2, 1'b1);
        push_digit(2'd0, 1'b0);
        push_idle(2);
        k = 0;
        while (sb.size() > 0) begin
            mask  = (k == 0) ? 4'b1111 : 4'b0101;
            start = (k < 16);
            stop  = (k == 15);
            @(posedge clk); #1;
            exp = sb.pop_front();
            n_checks++;
            if ({sel, en, busy, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL busy_mask_change cyc %0d: got sel=%b en=%b busy=%b fd=%b, want sel=%b en=%b busy=%b fd=%b",
                         k, sel, en, busy, frame_done, exp[4:3], exp[2], exp[1], exp[0]);
            end
            k++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_single_digit();
        test_stop();
        test_mask_drop();
        test_busy_mask_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
